// File: rtl/stack_arbiter.sv
// stack_arbiter
// Two-port round-robin arbiter in front of a single push/pop stack interface.
// Each requester issues a push or a pop and holds its strobe until it sees a
// one-cycle ACK (with ERR on a rejected or timed-out request). The block
// tracks stack occupancy itself, so pushes when full and pops when empty are
// rejected without touching the stack.
//
// Ports
//   CLK, RST                      clock, asynchronous active-high reset
//   Rn_PUSH_STB / Rn_POP_STB      requester n push / pop request (n = 0, 1)
//   Rn_PUSH_DAT                   requester n push data
//   Rn_POP_DAT                    last word popped for requester n
//   Rn_ACK / Rn_ERR               completion pulse / error flag for requester n
//   S_PUSH_STB, S_PUSH_DAT        push strobe and data to the stack
//   S_PUSH_ACK                    stack push acknowledge
//   S_POP_STB                     pop strobe to the stack
//   S_POP_DAT, S_POP_ACK          stack pop data and acknowledge
//   COUNT, EMPTY, FULL            occupancy and its flags
//   BUSY                          arbiter is not idle
module stack_arbiter #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TMO   = 15
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    R0_PUSH_STB,
    input  logic                    R0_POP_STB,
    input  logic [DW-1:0]           R0_PUSH_DAT,
    output logic [DW-1:0]           R0_POP_DAT,
    output logic                    R0_ACK,
    output logic                    R0_ERR,
    input  logic                    R1_PUSH_STB,
    input  logic                    R1_POP_STB,
    input  logic [DW-1:0]           R1_PUSH_DAT,
    output logic [DW-1:0]           R1_POP_DAT,
    output logic                    R1_ACK,
    output logic                    R1_ERR,
    output logic                    S_PUSH_STB,
    output logic [DW-1:0]           S_PUSH_DAT,
    input  logic                    S_PUSH_ACK,
    output logic                    S_POP_STB,
    input  logic [DW-1:0]           S_POP_DAT,
    input  logic                    S_POP_ACK,
    output logic [$clog2(DEPTH):0]  COUNT,
    output logic                    EMPTY,
    output logic                    FULL,
    output logic                    BUSY
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    // Wait counter only needs to reach TMO-1; the timeout fires in that cycle.
    localparam int unsigned WW = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic            gnt_q, gnt_d;          // last-granted port, also the active port
    logic            is_push_q, is_push_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DW-1:0]   push_dat_q, push_dat_d;
    logic [DW-1:0]   pop_dat0_q, pop_dat0_d;
    logic [DW-1:0]   pop_dat1_q, pop_dat1_d;
    logic            push_stb_q, push_stb_d;
    logic            pop_stb_q, pop_stb_d;
    logic [1:0]      ack_q, ack_d;
    logic [1:0]      err_q, err_d;
    logic            busy_q, busy_d;

    logic            req0, req1;
    logic            sel;
    logic            sel_push, sel_pop;
    logic [DW-1:0]   sel_dat;
    logic            reject;
    logic            ack_hit;
    logic            full_c, empty_c;

    assign req0    = R0_PUSH_STB | R0_POP_STB;
    assign req1    = R1_PUSH_STB | R1_POP_STB;
    assign full_c  = (count_q == CW'(DEPTH));
    assign empty_c = (count_q == '0);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        is_push_d  = is_push_q;
        wait_d     = wait_q;
        count_d    = count_q;
        push_dat_d = push_dat_q;
        pop_dat0_d = pop_dat0_q;
        pop_dat1_d = pop_dat1_q;
        push_stb_d = 1'b0;
        pop_stb_d  = 1'b0;
        ack_d      = 2'b00;
        err_d      = 2'b00;
        sel        = 1'b0;
        sel_push   = 1'b0;
        sel_pop    = 1'b0;
        sel_dat    = '0;
        reject     = 1'b0;
        ack_hit    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Contention goes to the port that was not granted last.
                    sel      = (req0 && req1) ? ~gnt_q : req1;
                    sel_push = sel ? R1_PUSH_STB : R0_PUSH_STB;
                    sel_pop  = sel ? R1_POP_STB  : R0_POP_STB;
                    sel_dat  = sel ? R1_PUSH_DAT : R0_PUSH_DAT;
                    reject   = (sel_push && sel_pop) || (sel_push && full_c) ||
                               (sel_pop && empty_c);
                    gnt_d     = sel;
                    is_push_d = sel_push;
                    if (reject) begin
                        state_d    = RESP;
                        ack_d[sel] = 1'b1;
                        err_d[sel] = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        wait_d  = '0;
                        if (sel_push) begin
                            push_stb_d = 1'b1;
                            push_dat_d = sel_dat;
                        end else begin
                            pop_stb_d = 1'b1;
                        end
                    end
                end
            end

            ISSUE: begin
                // Only the acknowledge matching the outstanding strobe counts.
                ack_hit = is_push_q ? S_PUSH_ACK : S_POP_ACK;
                if (ack_hit) begin
                    state_d      = RESP;
                    ack_d[gnt_q] = 1'b1;
                    if (is_push_q) begin
                        count_d = count_q + 1'b1;
                    end else begin
                        count_d = count_q - 1'b1;
                        if (gnt_q) begin
                            pop_dat1_d = S_POP_DAT;
                        end else begin
                            pop_dat0_d = S_POP_DAT;
                        end
                    end
                end else if (wait_q == WW'(TMO - 1)) begin
                    state_d      = RESP;
                    ack_d[gnt_q] = 1'b1;
                    err_d[gnt_q] = 1'b1;
                end else begin
                    wait_d     = wait_q + 1'b1;
                    push_stb_d = is_push_q;
                    pop_stb_d  = ~is_push_q;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b1;  // port 0 wins the first contention
            is_push_q  <= 1'b0;
            wait_q     <= '0;
            count_q    <= '0;
            push_dat_q <= '0;
            pop_dat0_q <= '0;
            pop_dat1_q <= '0;
            push_stb_q <= 1'b0;
            pop_stb_q  <= 1'b0;
            ack_q      <= 2'b00;
            err_q      <= 2'b00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            is_push_q  <= is_push_d;
            wait_q     <= wait_d;
            count_q    <= count_d;
            push_dat_q <= push_dat_d;
            pop_dat0_q <= pop_dat0_d;
            pop_dat1_q <= pop_dat1_d;
            push_stb_q <= push_stb_d;
            pop_stb_q  <= pop_stb_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign R0_POP_DAT = pop_dat0_q;
    assign R1_POP_DAT = pop_dat1_q;
    assign R0_ACK     = ack_q[0];
    assign R1_ACK     = ack_q[1];
    assign R0_ERR     = err_q[0];
    assign R1_ERR     = err_q[1];
    assign S_PUSH_STB = push_stb_q;
    assign S_PUSH_DAT = push_dat_q;
    assign S_POP_STB  = pop_stb_q;
    assign COUNT      = count_q;
    assign EMPTY      = empty_c;
    assign FULL       = full_c;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter
// Self-checking bench for stack_arbiter. A behavioural stack responder sits on
// the S_* side; a transaction-level model (occupancy counter, queue of stored
// words, last-granted port) predicts grant order, ERR, COUNT and popped data.
module tb_stack_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int TMO   = 15;

    logic          CLK = 1'b0;
    logic          RST;
    logic          R0_PUSH_STB, R0_POP_STB, R1_PUSH_STB, R1_POP_STB;
    logic [DW-1:0] R0_PUSH_DAT, R1_PUSH_DAT, R0_POP_DAT, R1_POP_DAT;
    logic          R0_ACK, R1_ACK, R0_ERR, R1_ERR;
    logic          S_PUSH_STB, S_POP_STB, S_PUSH_ACK, S_POP_ACK;
    logic [DW-1:0] S_PUSH_DAT, S_POP_DAT;
    logic [4:0]    COUNT;
    logic          EMPTY, FULL, BUSY;

    // Stack responder state
    logic          auto_push_ack = 1'b0;
    logic          auto_pop_ack  = 1'b0;
    logic          man_push_ack  = 1'b0;
    logic [DW-1:0] stk_pop_dat   = '0;
    logic [DW-1:0] stk_mem[$];
    int            stk_wait      = 0;
    bit            stk_en        = 1'b0;
    bit            stk_clr       = 1'b1;
    int            stk_delay     = 0;

    // Reference model
    int            m_cnt;
    logic [DW-1:0] m_q[$];
    int            m_last;
    logic [DW-1:0] m_pop[2];

    int            tests = 0;
    int            fails = 0;

    assign S_PUSH_ACK = auto_push_ack | man_push_ack;
    assign S_POP_ACK  = auto_pop_ack;
    assign S_POP_DAT  = stk_pop_dat;

    always #5 CLK = ~CLK;

    stack_arbiter #(.DW(DW), .DEPTH(DEPTH), .TMO(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .R0_PUSH_STB(R0_PUSH_STB), .R0_POP_STB(R0_POP_STB), .R0_PUSH_DAT(R0_PUSH_DAT),
        .R0_POP_DAT(R0_POP_DAT), .R0_ACK(R0_ACK), .R0_ERR(R0_ERR),
        .R1_PUSH_STB(R1_PUSH_STB), .R1_POP_STB(R1_POP_STB), .R1_PUSH_DAT(R1_PUSH_DAT),
        .R1_POP_DAT(R1_POP_DAT), .R1_ACK(R1_ACK), .R1_ERR(R1_ERR),
        .S_PUSH_STB(S_PUSH_STB), .S_PUSH_DAT(S_PUSH_DAT), .S_PUSH_ACK(S_PUSH_ACK),
        .S_POP_STB(S_POP_STB), .S_POP_DAT(S_POP_DAT), .S_POP_ACK(S_POP_ACK),
        .COUNT(COUNT), .EMPTY(EMPTY), .FULL(FULL), .BUSY(BUSY)
    );

    // Stack responder: acks after stk_delay extra strobe cycles, keeps real contents.
    always @(negedge CLK) begin
        if (stk_clr) begin
            stk_mem.delete();
            stk_wait      <= 0;
            auto_push_ack <= 1'b0;
            auto_pop_ack  <= 1'b0;
        end else if (auto_push_ack || auto_pop_ack) begin
            auto_push_ack <= 1'b0;
            auto_pop_ack  <= 1'b0;
            stk_wait      <= 0;
        end else if (stk_en && (S_PUSH_STB || S_POP_STB)) begin
            if (stk_wait >= stk_delay) begin
                if (S_PUSH_STB) begin
                    auto_push_ack <= 1'b1;
                    stk_mem.push_back(S_PUSH_DAT);
                end else begin
                    auto_pop_ack <= 1'b1;
                    if (stk_mem.size() > 0) stk_pop_dat <= stk_mem.pop_back();
                    else stk_pop_dat <= '0;
                end
            end else begin
                stk_wait <= stk_wait + 1;
            end
        end else begin
            stk_wait <= 0;
        end
    end

    task automatic model_reset();
        m_cnt = 0;
        m_q.delete();
        m_last = 1;
        m_pop[0] = '0;
        m_pop[1] = '0;
    endtask

    // op: 0 none, 1 push, 2 pop, 3 push+pop (illegal)
    task automatic model_serve(input int n, input int op, input logic [DW-1:0] d,
                               input bit noack, output logic err);
        m_last = n;
        if (op == 3 || (op == 1 && m_cnt == DEPTH) || (op == 2 && m_cnt == 0) || noack) begin
            err = 1'b1;
        end else begin
            err = 1'b0;
            if (op == 1) begin
                m_q.push_back(d);
                m_cnt++;
            end else begin
                m_pop[n] = m_q.pop_back();
                m_cnt--;
            end
        end
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        stk_clr = 1'b1;
        stk_en = 1'b0;
        man_push_ack = 1'b0;
        R0_PUSH_STB = 1'b0; R0_POP_STB = 1'b0; R0_PUSH_DAT = '0;
        R1_PUSH_STB = 1'b0; R1_POP_STB = 1'b0; R1_PUSH_DAT = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        stk_clr = 1'b0;
        model_reset();
    endtask

    // Presents op0/op1 simultaneously from idle and checks every ACK against the model.
    task automatic run_pair(input int op0, input int op1, input logic [DW-1:0] d0,
                            input logic [DW-1:0] d1, input bit noack, input string tag);
        int            order[$];
        int            ops[2];
        logic [DW-1:0] ds[2];
        bit            done[2];
        logic          exp_err, got_ack, got_err;
        logic [DW-1:0] got_pop;
        int            k;
        ops[0] = op0; ops[1] = op1; ds[0] = d0; ds[1] = d1;
        if (op0 != 0 && op1 != 0) begin
            if (m_last == 0) begin order.push_back(1); order.push_back(0); end
            else begin order.push_back(0); order.push_back(1); end
        end else if (op0 != 0) begin
            order.push_back(0);
        end else if (op1 != 0) begin
            order.push_back(1);
        end
        stk_en = !noack;
        stk_delay = $urandom_range(0, 3);
        R0_PUSH_STB = (op0 == 1 || op0 == 3); R0_POP_STB = (op0 == 2 || op0 == 3);
        R1_PUSH_STB = (op1 == 1 || op1 == 3); R1_POP_STB = (op1 == 2 || op1 == 3);
        R0_PUSH_DAT = d0; R1_PUSH_DAT = d1;
        done[0] = (op0 == 0); done[1] = (op1 == 0);
        k = 0;
        for (int cyc = 0; cyc < 100 && !(done[0] && done[1]); cyc++) begin
            @(negedge CLK);
            for (int n = 0; n < 2; n++) begin
                got_ack = (n == 0) ? R0_ACK : R1_ACK;
                got_err = (n == 0) ? R0_ERR : R1_ERR;
                got_pop = (n == 0) ? R0_POP_DAT : R1_POP_DAT;
                if (got_ack === 1'b1) begin
                    tests++;
                    if (done[n] || k >= order.size() || order[k] != n) begin
                        fails++;
                        $display("FAIL %s grant_order: ack on port %0d, ack index %0d", tag, n, k);
                    end
                    if (!done[n]) begin
                        model_serve(n, ops[n], ds[n], noack, exp_err);
                        tests++;
                        if (got_err !== exp_err) begin
                            fails++;
                            $display("FAIL %s err port %0d: got %b want %b", tag, n, got_err, exp_err);
                        end
                        tests++;
                        if (got_pop !== m_pop[n]) begin
                            fails++;
                            $display("FAIL %s pop_dat port %0d: got %h want %h", tag, n, got_pop,
                                     m_pop[n]);
                        end
                        tests++;
                        if (COUNT !== 5'(m_cnt)) begin
                            fails++;
                            $display("FAIL %s count: got %0d want %0d", tag, COUNT, m_cnt);
                        end
                        done[n] = 1'b1;
                        if (n == 0) begin R0_PUSH_STB = 1'b0; R0_POP_STB = 1'b0; end
                        else begin R1_PUSH_STB = 1'b0; R1_POP_STB = 1'b0; end
                    end
                    k++;
                end
            end
        end
        tests++;
        if (!(done[0] && done[1])) begin
            fails++;
            $display("FAIL %s ack_timeout: done0=%0d done1=%0d want both 1", tag, done[0], done[1]);
            R0_PUSH_STB = 1'b0; R0_POP_STB = 1'b0; R1_PUSH_STB = 1'b0; R1_POP_STB = 1'b0;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        R0_PUSH_STB = 1'b1; R0_POP_STB = 1'b0; R0_PUSH_DAT = 32'h1111_1111;
        R1_PUSH_STB = 1'b0; R1_POP_STB = 1'b1; R1_PUSH_DAT = '0;
        @(negedge CLK);
        tests++;
        if (COUNT !== 5'd0 || EMPTY !== 1'b1 || FULL !== 1'b0) begin
            fails++;
            $display("FAIL reset_count: got %0d/%b/%b want 0/1/0", COUNT, EMPTY, FULL);
        end
        tests++;
        if (BUSY !== 1'b0 || S_PUSH_STB !== 1'b0 || S_POP_STB !== 1'b0) begin
            fails++;
            $display("FAIL reset_strobes: busy=%b push=%b pop=%b want 0", BUSY, S_PUSH_STB, S_POP_STB);
        end
        tests++;
        if ({R0_ACK, R1_ACK, R0_ERR, R1_ERR} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ack: got %b want 0000", {R0_ACK, R1_ACK, R0_ERR, R1_ERR});
        end
        tests++;
        if (R0_POP_DAT !== '0 || R1_POP_DAT !== '0 || S_PUSH_DAT !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h %h %h want 0", R0_POP_DAT, R1_POP_DAT, S_PUSH_DAT);
        end
        apply_reset();
    endtask

    // Request presented in cycle 1, strobe in cycle 2, ACK in cycle 3.
    task automatic test_single_push();
        int   stb, ack_cyc;
        logic e;
        apply_reset();
        stk_en = 1'b1; stk_delay = 0;
        R0_PUSH_STB = 1'b1; R0_PUSH_DAT = 32'hA5;
        stb = 0; ack_cyc = 0; e = 1'bx;
        for (int c = 2; c < 20; c++) begin
            @(negedge CLK);
            if (S_PUSH_STB === 1'b1) begin
                stb++;
                tests++;
                if (S_PUSH_DAT !== 32'hA5) begin
                    fails++;
                    $display("FAIL push_dat: got %h want a5", S_PUSH_DAT);
                end
            end
            if (R0_ACK === 1'b1) begin ack_cyc = c; e = R0_ERR; break; end
        end
        R0_PUSH_STB = 1'b0;
        model_serve(0, 1, 32'hA5, 1'b0, e);
        tests++;
        if (ack_cyc != 3) begin fails++; $display("FAIL push_latency: got %0d want 3", ack_cyc); end
        tests++;
        if (stb != 1) begin fails++; $display("FAIL push_strobe_len: got %0d want 1", stb); end
        tests++;
        if (R0_ERR !== 1'b0 || COUNT !== 5'd1) begin
            fails++;
            $display("FAIL push_result: err=%b count=%0d want 0/1", R0_ERR, COUNT);
        end
        @(negedge CLK);
    endtask

    task automatic test_round_robin();
        apply_reset();
        stk_en = 1'b1;
        run_pair(1, 1, 32'h10, 32'h11, 1'b0, "rr1");
        run_pair(1, 1, 32'h20, 32'h21, 1'b0, "rr2");
        tests++;
        if (COUNT !== 5'd4) begin fails++; $display("FAIL rr_count: got %0d want 4", COUNT); end
    endtask

    task automatic test_pop_empty();
        int ack_cyc;
        bit strobe_seen;
        logic e;
        apply_reset();
        stk_en = 1'b1;
        R1_POP_STB = 1'b1;
        ack_cyc = 0; strobe_seen = 0; e = 1'bx;
        for (int c = 2; c < 20; c++) begin
            @(negedge CLK);
            if (S_POP_STB === 1'b1 || S_PUSH_STB === 1'b1) strobe_seen = 1;
            if (R1_ACK === 1'b1) begin ack_cyc = c; e = R1_ERR; break; end
        end
        R1_POP_STB = 1'b0;
        model_serve(1, 2, '0, 1'b0, e);
        tests++;
        if (ack_cyc != 2) begin fails++; $display("FAIL reject_latency: got %0d want 2", ack_cyc); end
        tests++;
        if (R1_ERR !== 1'b1 || R0_ACK !== 1'b0) begin
            fails++;
            $display("FAIL reject_err: r1_err=%b r0_ack=%b want 1/0", R1_ERR, R0_ACK);
        end
        tests++;
        if (strobe_seen || COUNT !== 5'd0 || EMPTY !== 1'b1) begin
            fails++;
            $display("FAIL reject_nostrobe: strobe=%0d count=%0d want 0/0", strobe_seen, COUNT);
        end
        @(negedge CLK);
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            run_pair(1, 0, (i == DEPTH - 1) ? 32'h3C : 32'($urandom), '0, 1'b0, "fill");
        end
        tests++;
        if (FULL !== 1'b1 || COUNT !== 5'd16) begin
            fails++;
            $display("FAIL full_flag: full=%b count=%0d want 1/16", FULL, COUNT);
        end
        run_pair(1, 0, 32'h77, '0, 1'b0, "push_full");
        tests++;
        if (COUNT !== 5'd16) begin fails++; $display("FAIL full_reject_count: got %0d want 16", COUNT); end
        run_pair(0, 2, '0, '0, 1'b0, "pop_full");
        tests++;
        if (R1_POP_DAT !== 32'h3C || COUNT !== 5'd15 || FULL !== 1'b0) begin
            fails++;
            $display("FAIL full_pop: dat=%h count=%0d full=%b want 3c/15/0", R1_POP_DAT, COUNT, FULL);
        end
    endtask

    task automatic test_timeout();
        int   stb, ack_cyc;
        logic e;
        apply_reset();
        stk_en = 1'b1;
        run_pair(1, 0, 32'hCAFE, '0, 1'b0, "pre_tmo");
        @(negedge CLK);
        stk_en = 1'b0;
        R0_PUSH_STB = 1'b1; R0_PUSH_DAT = 32'h1234_5678;
        stb = 0; ack_cyc = 0; e = 1'bx;
        for (int c = 2; c < 60; c++) begin
            @(negedge CLK);
            if (S_PUSH_STB === 1'b1) stb++;
            if (R0_ACK === 1'b1) begin ack_cyc = c; e = R0_ERR; break; end
        end
        R0_PUSH_STB = 1'b0;
        model_serve(0, 1, '0, 1'b1, e);
        tests++;
        if (stb != TMO) begin fails++; $display("FAIL tmo_strobe_len: got %0d want %0d", stb, TMO); end
        tests++;
        if (ack_cyc != TMO + 2) begin
            fails++;
            $display("FAIL tmo_latency: got %0d want %0d", ack_cyc, TMO + 2);
        end
        tests++;
        if (R0_ERR !== 1'b1 || COUNT !== 5'(m_cnt)) begin
            fails++;
            $display("FAIL tmo_result: err=%b count=%0d want 1/%0d", R0_ERR, COUNT, m_cnt);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_issue();
        bit ack_seen, stb_seen;
        apply_reset();
        stk_en = 1'b0;
        R0_PUSH_STB = 1'b1; R0_PUSH_DAT = 32'hDEAD_BEEF;
        repeat (3) @(negedge CLK);
        tests++;
        if (S_PUSH_STB !== 1'b1) begin fails++; $display("FAIL mid_issue_pre: strobe=%b want 1", S_PUSH_STB); end
        #2;
        RST = 1'b1;
        R0_PUSH_STB = 1'b0;
        #1;
        tests++;
        if (S_PUSH_STB !== 1'b0 || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: strobe=%b busy=%b want 0/0", S_PUSH_STB, BUSY);
        end
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        man_push_ack = 1'b1;
        ack_seen = 0; stb_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (c == 1) man_push_ack = 1'b0;
            if (R0_ACK === 1'b1 || R1_ACK === 1'b1) ack_seen = 1;
            if (S_PUSH_STB === 1'b1) stb_seen = 1;
        end
        man_push_ack = 1'b0;
        tests++;
        if (ack_seen || stb_seen || COUNT !== 5'd0) begin
            fails++;
            $display("FAIL late_ack: ack=%0d strobe=%0d count=%0d want 0/0/0", ack_seen, stb_seen, COUNT);
        end
    endtask

    task automatic test_random();
        int op[2];
        int r;
        bit noack;
        apply_reset();
        for (int it = 0; it < 80; it++) begin
            for (int n = 0; n < 2; n++) begin
                r = $urandom_range(0, 9);
                op[n] = (r < 2) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
            end
            if (op[0] == 0 && op[1] == 0) op[0] = 1;
            noack = ($urandom_range(0, 11) == 0);
            run_pair(op[0], op[1], 32'($urandom), 32'($urandom), noack, "random");
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_push();
        test_round_robin();
        test_pop_empty();
        test_full();
        test_timeout();
        test_reset_mid_issue();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
